// File: rtl/fifo_link_arb_pkg.sv
// fifo_link_arb_pkg: shared helpers and defaults for the FIFO link reader arbiter
package fifo_link_arb_pkg;
   localparam int unsigned NUM_REQ_DEF = 2;
   localparam logic [31:0] ERR_RDATA_DEF = 32'hBADCAB1E;
   function automatic int unsigned idx_w(input int unsigned n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   typedef logic [idx_w(NUM_REQ_DEF)-1:0] idx_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO; push ignored when full, pop ignored when empty
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);
   localparam int unsigned PtrW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   logic [PtrW-1:0] rd_q, wr_q;
   logic [CntW-1:0] cnt_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic do_push, do_pop, unused_testmode;
   function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
      return p == PtrW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign unused_testmode = testmode_i;
   assign full_o  = cnt_q == CntW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign data_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         mem_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= inc(wr_q);
         end
         if (do_pop) rd_q <= inc(rd_q);
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end
endmodule

// File: rtl/fifo_link_reader_arbiter.sv
// fifo_link_reader_arbiter: round-robin OBI arbiter sharing the FIFO reader port;
// reads are forwarded and tracked by ID, writes are rejected locally with an error word.
module fifo_link_reader_arbiter
   import fifo_link_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEF)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_REQ-1:0]                   m_req_i,
   output logic [NUM_REQ-1:0]                   m_gnt_o,
   output logic [NUM_REQ-1:0]                   m_rvalid_o,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [NUM_REQ-1:0]                   m_we_i,
   input  logic [NUM_REQ-1:0][3:0]              m_be_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   m_wdata_i,
   output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   m_rdata_o,
   output logic                                 fifo_req_o,
   input  logic                                 fifo_gnt_i,
   input  logic                                 fifo_rvalid_i,
   output logic [ADDR_WIDTH-1:0]                fifo_addr_o,
   output logic                                 fifo_we_o,
   output logic [3:0]                           fifo_be_o,
   input  logic [DATA_WIDTH-1:0]                fifo_rdata_i,
   output logic [15:0]                          reject_cnt_o,
   output logic                                 spurious_rvalid_o
);
   localparam int unsigned IdxW = idx_w(NUM_REQ);
   logic [IdxW-1:0] ptr_q, lock_idx_q, wr_idx_q, pick, winner, head;
   logic [NUM_REQ-1:0] req_hi;
   logic [15:0] reject_cnt_q;
   logic lock_q, wr_rsp_q, spurious_q, id_full, id_empty;
   logic rd, rd_hs, wr_gnt, pop, unused_wdata;

   assign unused_wdata = ^m_wdata_i;

   // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      req_hi = '0;
      pick = '0;
      for (int j = 0; j < NUM_REQ; j++) req_hi[j] = m_req_i[j] & (j >= int'(ptr_q));
      for (int j = NUM_REQ - 1; j >= 0; j--) if (m_req_i[j]) pick = IdxW'(j);
      for (int j = NUM_REQ - 1; j >= 0; j--) if (req_hi[j]) pick = IdxW'(j);
   end

   assign winner      = lock_q ? lock_idx_q : pick;
   assign rd          = m_req_i[winner] & ~m_we_i[winner];
   assign fifo_req_o  = rd & ~id_full;
   assign rd_hs       = fifo_req_o & fifo_gnt_i;
   assign wr_gnt      = m_req_i[winner] & m_we_i[winner] & id_empty & ~lock_q;
   assign m_gnt_o     = (rd_hs | wr_gnt) ? NUM_REQ'(1) << winner : '0;
   assign fifo_addr_o = fifo_req_o ? m_addr_i[winner] : '0;
   assign fifo_be_o   = fifo_req_o ? m_be_i[winner] : '0;
   assign fifo_we_o   = 1'b0;
   assign pop         = fifo_rvalid_i & ~id_empty;
   assign reject_cnt_o      = reject_cnt_q;
   assign spurious_rvalid_o = spurious_q;

   fifo_v3 #(.DATA_WIDTH(IdxW), .DEPTH(MAX_OUTSTANDING)) i_id_queue (
      .clk_i, .rst_ni, .flush_i(1'b0), .testmode_i(1'b0),
      .full_o(id_full), .empty_o(id_empty),
      .data_i(winner), .push_i(rd_hs), .data_o(head), .pop_i(pop)
   );

   // A write response can never meet a FIFO response: writes need an empty ID queue.
   always_comb begin
      m_rvalid_o = '0;
      m_rdata_o = '0;
      if (pop) begin
         m_rvalid_o[head] = 1'b1;
         m_rdata_o[head]  = fifo_rdata_i;
      end else if (wr_rsp_q) begin
         m_rvalid_o[wr_idx_q] = 1'b1;
         m_rdata_o[wr_idx_q]  = ERR_RDATA;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q        <= '0;
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         wr_rsp_q     <= 1'b0;
         wr_idx_q     <= '0;
         reject_cnt_q <= '0;
         spurious_q   <= 1'b0;
      end else begin
         if (rd_hs | wr_gnt) ptr_q <= (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         if (rd_hs) lock_q <= 1'b0;
         else if (fifo_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
         end
         wr_rsp_q <= wr_gnt;
         wr_idx_q <= winner;
         if (wr_gnt && reject_cnt_q != '1) reject_cnt_q <= reject_cnt_q + 16'd1;
         if (fifo_rvalid_i & id_empty) spurious_q <= 1'b1;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_gnt_o));
   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_rvalid_o));
endmodule

// File: tb/tb_fifo_link_reader_arbiter.sv
// tb_fifo_link_reader_arbiter: directed checks of arbitration, locking, ID routing and write rejection
module tb_fifo_link_reader_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [1:0] m_req, m_we, m_gnt, m_rvalid;
  logic [1:0][31:0] m_addr, m_wdata, m_rdata;
  logic [1:0][3:0] m_be;
  logic fifo_req, fifo_gnt, fifo_rvalid, fifo_we, spurious;
  logic [31:0] fifo_addr, fifo_rdata;
  logic [3:0] fifo_be;
  logic [15:0] reject_cnt;
  int n_vec = 0;
  int n_err = 0;
  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  always #5 clk_i = ~clk_i;
  fifo_link_reader_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
    .fifo_req_o(fifo_req), .fifo_gnt_i(fifo_gnt), .fifo_rvalid_i(fifo_rvalid),
    .fifo_addr_o(fifo_addr), .fifo_we_o(fifo_we), .fifo_be_o(fifo_be), .fifo_rdata_i(fifo_rdata),
    .reject_cnt_o(reject_cnt), .spurious_rvalid_o(spurious)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  initial begin
    rst_ni = 1'b0;
    m_req = '0; m_we = '0; m_wdata = '0;
    m_addr[0] = A0; m_addr[1] = A1;
    m_be[0] = 4'hF; m_be[1] = 4'h3;
    fifo_gnt = 1'b0; fifo_rvalid = 1'b0; fifo_rdata = '0;
    #3;
    chk("rst_gnt", m_gnt, 2'b00);
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_rdata", m_rdata, 64'h0);
    chk("rst_req", fifo_req, 1'b0);
    chk("rst_addr", fifo_addr, 32'h0);
    chk("rst_be", fifo_be, 4'h0);
    chk("rst_rej", reject_cnt, 16'h0);
    chk("rst_spur", spurious, 1'b0);
    tick(); tick();
    rst_ni = 1'b1;
    tick(); m_req = 2'b11; fifo_gnt = 1'b1; #1;
    chk("t1_req", fifo_req, 1'b1);
    chk("t1_gnt0", m_gnt, 2'b01);
    chk("t1_addr0", fifo_addr, A0);
    tick(); m_req = 2'b10; fifo_rvalid = 1'b1; fifo_rdata = 32'h11; #1;
    chk("t1_gnt1", m_gnt, 2'b10);
    chk("t1_addr1", fifo_addr, A1);
    chk("t1_rv0", m_rvalid, 2'b01);
    chk("t1_rd0", m_rdata[0], 32'h11);
    chk("t1_rd1z", m_rdata[1], 32'h0);
    tick(); m_req = 2'b00; fifo_gnt = 1'b0; fifo_rdata = 32'h22; #1;
    chk("t1_rv1", m_rvalid, 2'b10);
    chk("t1_rd1", m_rdata[1], 32'h22);
    chk("t1_rd0z", m_rdata[0], 32'h0);
    tick(); fifo_rvalid = 1'b0; #1;
    chk("t1_idle", m_rvalid, 2'b00);
    tick(); m_req = 2'b10; #1;
    chk("t2_req", fifo_req, 1'b1);
    chk("t2_nogr", m_gnt, 2'b00);
    chk("t2_addr_a", fifo_addr, A1);
    tick(); #1;
    chk("t2_addr_b", fifo_addr, A1);
    tick(); #1;
    chk("t2_addr_c", fifo_addr, A1);
    tick(); m_req = 2'b11; #1;
    chk("t2_lock_addr", fifo_addr, A1);
    chk("t2_lock_gnt", m_gnt, 2'b00);
    tick(); fifo_gnt = 1'b1; #1;
    chk("t2_gnt1", m_gnt, 2'b10);
    chk("t2_gaddr", fifo_addr, A1);
    tick(); m_req = 2'b01; fifo_gnt = 1'b0; fifo_rvalid = 1'b1; fifo_rdata = 32'hAA; #1;
    chk("t2_rv1", m_rvalid, 2'b10);
    chk("t2_rd1", m_rdata[1], 32'hAA);
    chk("t2_m0req", fifo_req, 1'b1);
    chk("t2_m0addr", fifo_addr, A0);
    tick(); fifo_rvalid = 1'b0; fifo_gnt = 1'b1; #1;
    chk("t2_gnt0", m_gnt, 2'b01);
    tick(); m_req = 2'b00; fifo_gnt = 1'b0; fifo_rvalid = 1'b1; fifo_rdata = 32'hBB; #1;
    chk("t2_rv0", m_rvalid, 2'b01);
    chk("t2_rd0", m_rdata[0], 32'hBB);
    tick(); fifo_rvalid = 1'b0;
    tick(); m_req = 2'b01; m_we = 2'b01; #1;
    chk("t3_gnt", m_gnt, 2'b01);
    chk("t3_noreq", fifo_req, 1'b0);
    tick(); m_req = 2'b00; m_we = 2'b00; #1;
    chk("t3_rv", m_rvalid, 2'b01);
    chk("t3_rd", m_rdata[0], 32'hBADCAB1E);
    chk("t3_rej", reject_cnt, 16'd1);
    chk("t3_noreq2", fifo_req, 1'b0);
    tick(); #1;
    chk("t3_rv_off", m_rvalid, 2'b00);
    tick(); m_req = 2'b10; fifo_gnt = 1'b1; #1;
    chk("t4_g1", m_gnt, 2'b10);
    chk("t4_be", fifo_be, 4'h3);
    chk("t4_we", fifo_we, 1'b0);
    tick(); m_req = 2'b01; #1;
    chk("t4_g2", m_gnt, 2'b01);
    tick(); m_req = 2'b10; #1;
    chk("t4_full_req", fifo_req, 1'b0);
    chk("t4_full_gnt", m_gnt, 2'b00);
    tick(); fifo_rvalid = 1'b1; fifo_rdata = 32'h31; #1;
    chk("t4_rv1", m_rvalid, 2'b10);
    chk("t4_rd1", m_rdata[1], 32'h31);
    chk("t4_still", m_gnt, 2'b00);
    tick(); fifo_rvalid = 1'b0; #1;
    chk("t4_g3", m_gnt, 2'b10);
    tick(); m_req = 2'b00; fifo_gnt = 1'b0; fifo_rvalid = 1'b1; fifo_rdata = 32'h32; #1;
    chk("t4_rv0", m_rvalid, 2'b01);
    chk("t4_rd0", m_rdata[0], 32'h32);
    tick(); fifo_rdata = 32'h33; #1;
    chk("t4_rv3", m_rvalid, 2'b10);
    chk("t4_rd3", m_rdata[1], 32'h33);
    tick(); fifo_rvalid = 1'b0;
    tick(); fifo_rvalid = 1'b1; fifo_rdata = 32'h55; #1;
    chk("t5_norv", m_rvalid, 2'b00);
    chk("t5_nord", m_rdata, 64'h0);
    tick(); fifo_rvalid = 1'b0; #1;
    chk("t5_spur", spurious, 1'b1);
    tick(); tick(); #1;
    chk("t5_sticky", spurious, 1'b1);
    tick(); m_req = 2'b01; fifo_gnt = 1'b1; #1;
    chk("t6_gnt", m_gnt, 2'b01);
    tick(); m_req = 2'b00; fifo_gnt = 1'b0; rst_ni = 1'b0; #1;
    chk("t6_rv", m_rvalid, 2'b00);
    chk("t6_spur", spurious, 1'b0);
    chk("t6_rej", reject_cnt, 16'h0);
    chk("t6_req", fifo_req, 1'b0);
    tick(); tick(); rst_ni = 1'b1;
    tick(); fifo_rvalid = 1'b1; fifo_rdata = 32'h66; #1;
    chk("t6_late", m_rvalid, 2'b00);
    tick(); fifo_rvalid = 1'b0; m_req = 2'b11; fifo_gnt = 1'b1; #1;
    chk("t6_ptr0", m_gnt, 2'b01);
    tick(); m_req = 2'b00; fifo_gnt = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
